// File: rtl/load_aligner_if.sv
// load_aligner_if: bundles the three handshakes around the load aligner.
//   req_*      : load request from the LSU address stage (valid/ready).
//   mem_req_*  : beat read request to the data bus (valid/ready).
//   mem_rsp_*  : read data returned by the bus (valid only, no backpressure).
//   wb_*       : extended load result towards register-file writeback.
// Modports:
//   slave  - the load_aligner view (takes requests, drives bus reads and results).
//   master - the surrounding LSU/bus/writeback environment.
interface load_aligner_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_f3;
  logic [4:0]        req_rd;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_rsp_valid;
  logic [XLEN-1:0]   mem_rsp_data;

  logic              wb_valid;
  logic              wb_ready;
  logic [XLEN-1:0]   wb_data;
  logic [4:0]        wb_rd;
  logic              wb_fault;

  modport slave (
    input  req_valid, req_addr, req_f3, req_rd,
    output req_ready,
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output wb_valid, wb_data, wb_rd, wb_fault,
    input  wb_ready
  );

  modport master (
    output req_valid, req_addr, req_f3, req_rd,
    input  req_ready,
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  wb_valid, wb_data, wb_rd, wb_fault,
    output wb_ready
  );
endinterface

// File: rtl/load_aligner.sv
// load_aligner: multi-cycle load data unit between the LSU address stage and
// register-file writeback. Takes one load request, issues one (or two, for a
// load straddling a bus beat) naturally aligned bus reads, merges the beats,
// extracts the addressed byte/half/word/dword and sign/zero-extends it.
//
// Parameters: XLEN (32 or 64, datapath/bus width), ADDR_W (byte address width).
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - load_aligner_if.slave: req_* request handshake, mem_req_*/mem_rsp_*
//          bus read channel, wb_* registered result handshake.
//
// Build option: define LOAD_MISALIGN_EN to service loads that cross a beat
// boundary with two bus reads. Without it such loads complete immediately with
// wb_fault=1 and the second-beat states are not built.
module load_aligner #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  load_aligner_if.slave bus
);

  localparam int BYTES = XLEN / 8;
  localparam int OFF_W = $clog2(BYTES);

  typedef enum logic [2:0] {IDLE, REQ0, RSP0, REQ1, RSP1, DONE} state_t;

  state_t            state_q;
  state_t            state_d;

  logic [OFF_W-1:0]  off_q;
  logic [2:0]        f3_q;
  logic [4:0]        rd_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [XLEN-1:0]   wb_data_q;
  logic              wb_fault_q;
  logic              wb_valid_q;
`ifdef LOAD_MISALIGN_EN
  logic              split_q;
  logic [XLEN-1:0]   beat0_q;
`endif

  // Masks the field down to its access size and extends it to XLEN.
  // For a full-width access the mask is all ones, so the value passes through.
  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] field,
                                             input logic [2:0]      f3);
    logic [XLEN-1:0] mask;
    logic            sign;
    case (f3[1:0])
      2'b00:   begin mask = XLEN'(8'hFF);         sign = field[7];  end
      2'b01:   begin mask = XLEN'(16'hFFFF);      sign = field[15]; end
      2'b10:   begin mask = XLEN'(32'hFFFF_FFFF); sign = field[31]; end
      default: begin mask = '1;                   sign = 1'b0;      end
    endcase
    sign = sign & ~f3[2];
    return (field & mask) | ({XLEN{sign}} & ~mask);
  endfunction

  // Request decode, only meaningful while IDLE.
  logic [OFF_W-1:0] req_off;
  logic [3:0]       req_size;
  logic [4:0]       req_end;
  logic             req_split;
  logic             req_bad_f3;
  logic             req_fault;

  assign req_off    = bus.req_addr[OFF_W-1:0];
  assign req_size   = 4'd1 << bus.req_f3[1:0];
  assign req_end    = 5'(req_off) + 5'(req_size);
  assign req_split  = (req_end > 5'(BYTES));
  assign req_bad_f3 = (bus.req_f3 == 3'b111) ||
                      ((XLEN == 32) && ((bus.req_f3 == 3'b011) || (bus.req_f3 == 3'b110)));
`ifdef LOAD_MISALIGN_EN
  assign req_fault  = req_bad_f3;
`else
  assign req_fault  = req_bad_f3 | req_split;
`endif

  // Merge: the low beat is the live response on a single-beat load and the
  // captured beat0 once the second beat is arriving.
  logic [XLEN-1:0] merge_lo;
  logic [XLEN-1:0] merge_hi;
  logic [XLEN-1:0] field;
  logic [XLEN-1:0] ld_result;

`ifdef LOAD_MISALIGN_EN
  assign merge_lo = (state_q == RSP1) ? beat0_q : bus.mem_rsp_data;
  assign merge_hi = (state_q == RSP1) ? bus.mem_rsp_data : '0;
`else
  assign merge_lo = bus.mem_rsp_data;
  assign merge_hi = '0;
`endif
  assign field     = XLEN'({merge_hi, merge_lo} >> {off_q, 3'b000});
  assign ld_result = extend(field, f3_q);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.req_valid)     state_d = req_fault ? DONE : REQ0;
      REQ0: if (bus.mem_req_ready) state_d = RSP0;
`ifdef LOAD_MISALIGN_EN
      RSP0: if (bus.mem_rsp_valid) state_d = split_q ? REQ1 : DONE;
      REQ1: if (bus.mem_req_ready) state_d = RSP1;
      RSP1: if (bus.mem_rsp_valid) state_d = DONE;
`else
      RSP0: if (bus.mem_rsp_valid) state_d = DONE;
`endif
      DONE: if (bus.wb_ready)      state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    bus.req_ready     = 1'b0;
    bus.mem_req_valid = 1'b0;
    case (state_q)
      IDLE:    bus.req_ready     = 1'b1;
      REQ0:    bus.mem_req_valid = 1'b1;
`ifdef LOAD_MISALIGN_EN
      REQ1:    bus.mem_req_valid = 1'b1;
`endif
      default: ;
    endcase
  end

  // Captured request, beat address and registered result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off_q      <= '0;
      f3_q       <= '0;
      rd_q       <= '0;
      mem_addr_q <= '0;
      wb_data_q  <= '0;
      wb_fault_q <= 1'b0;
      wb_valid_q <= 1'b0;
`ifdef LOAD_MISALIGN_EN
      split_q    <= 1'b0;
      beat0_q    <= '0;
`endif
    end else begin
      wb_valid_q <= (state_d == DONE);
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            off_q      <= req_off;
            f3_q       <= bus.req_f3;
            rd_q       <= bus.req_rd;
            mem_addr_q <= {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            wb_fault_q <= req_fault;
            if (req_fault) wb_data_q <= '0;
`ifdef LOAD_MISALIGN_EN
            split_q    <= req_split;
`endif
          end
        end
        RSP0: begin
          if (bus.mem_rsp_valid) begin
`ifdef LOAD_MISALIGN_EN
            beat0_q <= bus.mem_rsp_data;
            // Second beat address wraps naturally at 2^ADDR_W.
            if (split_q) mem_addr_q <= mem_addr_q + ADDR_W'(BYTES);
            else         wb_data_q  <= ld_result;
`else
            wb_data_q <= ld_result;
`endif
          end
        end
`ifdef LOAD_MISALIGN_EN
        RSP1: begin
          if (bus.mem_rsp_valid) wb_data_q <= ld_result;
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.mem_req_addr = mem_addr_q;
  assign bus.wb_valid     = wb_valid_q;
  assign bus.wb_data      = wb_data_q;
  assign bus.wb_rd        = rd_q;
  assign bus.wb_fault     = wb_fault_q;

endmodule

// File: tb/tb_load_aligner.sv
// tb_load_aligner: directed testbench for load_aligner, one XLEN=32 and one
// XLEN=64 instance sharing clock and reset. A cycle-stepping runner task acts
// as LSU, zero-wait bus (optionally stalled) and writeback; scenario tasks
// compare its observations against hand-computed values.
module tb_load_aligner;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  load_aligner_if #(.XLEN(32), .ADDR_W(32)) if32 ();
  load_aligner_if #(.XLEN(64), .ADDR_W(32)) if64 ();

  load_aligner #(.XLEN(32), .ADDR_W(32)) dut32 (.clk(clk), .rst(rst), .bus(if32));
  load_aligner #(.XLEN(64), .ADDR_W(32)) dut64 (.clk(clk), .rst(rst), .bus(if64));

  int total;
  int bad;

  // Runner observations
  logic [63:0] r_data;
  logic        r_fault;
  logic [4:0]  r_rd;
  int          r_nreq;
  logic [31:0] r_a0;
  logic [31:0] r_a1;
  int          r_lat;
  bit          r_stable;

  task automatic idle_inputs();
    if32.req_valid = 1'b0; if32.req_addr = '0; if32.req_f3 = '0; if32.req_rd = '0;
    if32.mem_req_ready = 1'b1; if32.mem_rsp_valid = 1'b0; if32.mem_rsp_data = '0;
    if32.wb_ready = 1'b1;
    if64.req_valid = 1'b0; if64.req_addr = '0; if64.req_f3 = '0; if64.req_rd = '0;
    if64.mem_req_ready = 1'b1; if64.mem_rsp_valid = 1'b0; if64.mem_rsp_data = '0;
    if64.wb_ready = 1'b1;
  endtask

  // Issues one load at cycle T and plays bus/writeback until the result is
  // taken. stall = cycles mem_req_ready is held low on the first request;
  // hold = cycles wb_ready is held low after wb_valid. r_lat = cycles after T.
  task automatic run_load(input bit w64, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [4:0] rd, input logic [63:0] b0, input logic [63:0] b1,
                          input int stall, input int hold);
    bit          done, pend, have_hold;
    int          nrsp, stall_left, hold_left;
    logic        mrv, rdy, wbv, wbr, rq, wf;
    logic [31:0] maddr, hold_addr;
    logic [63:0] wd, rdata;
    logic [4:0]  wr;
    r_nreq = 0; r_a0 = '0; r_a1 = '0; r_lat = -1; r_stable = 1'b1;
    r_data = '0; r_fault = 1'b0; r_rd = '0;
    done = 1'b0; pend = 1'b0; have_hold = 1'b0; nrsp = 0;
    stall_left = stall; hold_left = hold; hold_addr = '0;
    if (w64) begin
      if64.req_valid = 1'b1; if64.req_addr = addr; if64.req_f3 = f3; if64.req_rd = rd;
    end else begin
      if32.req_valid = 1'b1; if32.req_addr = addr; if32.req_f3 = f3; if32.req_rd = rd;
    end
    @(posedge clk); #1;
    if32.req_valid = 1'b0;
    if64.req_valid = 1'b0;
    for (int i = 1; i <= 40 && !done; i++) begin
      rdy   = (stall_left == 0);
      wbr   = (hold_left == 0);
      rdata = (nrsp == 0) ? b0 : b1;
      if (w64) begin
        if64.mem_rsp_valid = pend; if64.mem_rsp_data = rdata;
        if64.mem_req_ready = rdy;  if64.wb_ready = wbr;
        mrv = if64.mem_req_valid; maddr = if64.mem_req_addr; wbv = if64.wb_valid;
        wd = if64.wb_data; wf = if64.wb_fault; wr = if64.wb_rd; rq = if64.req_ready;
      end else begin
        if32.mem_rsp_valid = pend; if32.mem_rsp_data = rdata[31:0];
        if32.mem_req_ready = rdy;  if32.wb_ready = wbr;
        mrv = if32.mem_req_valid; maddr = if32.mem_req_addr; wbv = if32.wb_valid;
        wd = {32'h0, if32.wb_data}; wf = if32.wb_fault; wr = if32.wb_rd; rq = if32.req_ready;
      end
      if (pend) nrsp++;
      pend = 1'b0;
      if (mrv) begin
        if (have_hold && maddr !== hold_addr) r_stable = 1'b0;
        if (rdy) begin
          if (r_nreq == 0) r_a0 = maddr; else r_a1 = maddr;
          r_nreq++;
          pend = 1'b1;
          have_hold = 1'b0;
        end else begin
          hold_addr = maddr; have_hold = 1'b1;
          stall_left--;
        end
      end
      if (wbv) begin
        if (r_lat < 0) begin
          r_lat = i; r_data = wd; r_fault = wf; r_rd = wr;
        end else if (wd !== r_data || wf !== r_fault || wr !== r_rd) begin
          r_stable = 1'b0;
        end
        if (rq !== 1'b0) r_stable = 1'b0;
        if (wbr) done = 1'b1; else hold_left--;
      end else if (r_lat >= 0) begin
        r_stable = 1'b0;
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    total++; if (if32.req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready: got %b want 1", if32.req_ready); end
    total++; if (if32.mem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_mem_req_valid: got %b want 0", if32.mem_req_valid); end
    total++; if (if32.wb_valid !== 1'b0 || if32.wb_fault !== 1'b0) begin bad++; $display("FAIL reset_wb_flags: got valid=%b fault=%b want 0 0", if32.wb_valid, if32.wb_fault); end
    total++; if (if32.wb_data !== 32'h0 || if32.wb_rd !== 5'd0 || if32.mem_req_addr !== 32'h0) begin
      bad++; $display("FAIL reset_regs: got data=%h rd=%0d addr=%h want 0", if32.wb_data, if32.wb_rd, if32.mem_req_addr); end
    total++; if (if64.req_ready !== 1'b1 || if64.wb_valid !== 1'b0 || if64.wb_data !== 64'h0) begin
      bad++; $display("FAIL reset_x64: got ready=%b valid=%b data=%h want 1 0 0", if64.req_ready, if64.wb_valid, if64.wb_data); end
    rst = 1'b0;
  endtask

  task automatic test_aligned32();
    run_load(1'b0, 32'h100, 3'b010, 5'd5, 64'hDEADBEEF, 64'h0, 0, 0);
    total++; if (r_nreq != 1 || r_a0 !== 32'h100) begin bad++; $display("FAIL lw_addr: got n=%0d addr=%h want 1 00000100", r_nreq, r_a0); end
    total++; if (r_data !== 64'hDEADBEEF || r_fault !== 1'b0) begin bad++; $display("FAIL lw_data: got %h f=%b want deadbeef f=0", r_data, r_fault); end
    total++; if (r_lat != 3) begin bad++; $display("FAIL lw_latency: got %0d want 3", r_lat); end
    total++; if (r_rd !== 5'd5) begin bad++; $display("FAIL lw_rd: got %0d want 5", r_rd); end
  endtask

  task automatic test_extend32();
    logic [31:0] a [5];
    logic [2:0]  f [5];
    logic [31:0] e [5];
    a[0] = 32'h103; f[0] = 3'b000; e[0] = 32'hFFFFFF80;
    a[1] = 32'h103; f[1] = 3'b100; e[1] = 32'h00000080;
    a[2] = 32'h102; f[2] = 3'b101; e[2] = 32'h000080AA;
    a[3] = 32'h102; f[3] = 3'b001; e[3] = 32'hFFFF80AA;
    a[4] = 32'h101; f[4] = 3'b000; e[4] = 32'h00000055;
    for (int k = 0; k < 5; k++) begin
      run_load(1'b0, a[k], f[k], 5'(k + 10), 64'h80AA5511, 64'h0, 0, 0);
      total++;
      if (r_data !== {32'h0, e[k]} || r_fault !== 1'b0 || r_a0 !== 32'h100) begin
        bad++; $display("FAIL extend32[%0d]: got %h f=%b addr=%h want %h f=0 addr=00000100", k, r_data, r_fault, r_a0, e[k]);
      end
    end
  endtask

  task automatic test_split32();
    run_load(1'b0, 32'h103, 3'b001, 5'd6, 64'h44332211, 64'h88776655, 0, 0);
`ifdef LOAD_MISALIGN_EN
    total++; if (r_nreq != 2 || r_a0 !== 32'h100 || r_a1 !== 32'h104) begin
      bad++; $display("FAIL split_addrs: got n=%0d %h %h want 2 00000100 00000104", r_nreq, r_a0, r_a1); end
    total++; if (r_data !== 64'h5544 || r_fault !== 1'b0) begin bad++; $display("FAIL split_data: got %h f=%b want 5544 f=0", r_data, r_fault); end
    total++; if (r_lat != 5) begin bad++; $display("FAIL split_latency: got %0d want 5", r_lat); end
    run_load(1'b0, 32'hFFFFFFFF, 3'b001, 5'd6, 64'h44332211, 64'h88776655, 0, 0);
    total++; if (r_nreq != 2 || r_a0 !== 32'hFFFFFFFC || r_a1 !== 32'h0 || r_data !== 64'h5544) begin
      bad++; $display("FAIL split_wrap: got n=%0d %h %h d=%h want 2 fffffffc 00000000 5544", r_nreq, r_a0, r_a1, r_data); end
`else
    total++; if (r_fault !== 1'b1 || r_data !== 64'h0 || r_nreq != 0) begin
      bad++; $display("FAIL split_fault: got f=%b d=%h n=%0d want 1 0 0", r_fault, r_data, r_nreq); end
    total++; if (r_lat != 1) begin bad++; $display("FAIL split_fault_latency: got %0d want 1", r_lat); end
`endif
  endtask

  task automatic test_illegal();
    bit         w [4];
    logic [2:0] f [4];
    w[0] = 1'b0; f[0] = 3'b011;
    w[1] = 1'b0; f[1] = 3'b110;
    w[2] = 1'b0; f[2] = 3'b111;
    w[3] = 1'b1; f[3] = 3'b111;
    for (int k = 0; k < 4; k++) begin
      run_load(w[k], 32'h100, f[k], 5'd17, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 0, 0);
      total++;
      if (r_fault !== 1'b1 || r_data !== 64'h0 || r_nreq != 0 || r_lat != 1 || r_rd !== 5'd17) begin
        bad++; $display("FAIL illegal[%0d]: got f=%b d=%h n=%0d lat=%0d rd=%0d want 1 0 0 1 17", k, r_fault, r_data, r_nreq, r_lat, r_rd);
      end
    end
  endtask

  task automatic test_xlen64();
    run_load(1'b1, 32'h8, 3'b011, 5'd2, 64'h8000000000000001, 64'h0, 0, 0);
    total++; if (r_data !== 64'h8000000000000001 || r_a0 !== 32'h8 || r_lat != 3) begin
      bad++; $display("FAIL ld64: got %h addr=%h lat=%0d want 8000000000000001 00000008 3", r_data, r_a0, r_lat); end
    run_load(1'b1, 32'hC, 3'b110, 5'd2, 64'h8765432112345678, 64'h0, 0, 0);
    total++; if (r_data !== 64'h0000000087654321 || r_a0 !== 32'h8) begin
      bad++; $display("FAIL lwu64: got %h addr=%h want 0000000087654321 00000008", r_data, r_a0); end
    run_load(1'b1, 32'h10, 3'b010, 5'd2, 64'h0000000080000000, 64'h0, 0, 0);
    total++; if (r_data !== 64'hFFFFFFFF80000000 || r_fault !== 1'b0) begin
      bad++; $display("FAIL lw64_sign: got %h f=%b want ffffffff80000000 f=0", r_data, r_fault); end
    run_load(1'b1, 32'hF, 3'b000, 5'd2, 64'h8000000000000000, 64'h0, 0, 0);
    total++; if (r_data !== 64'hFFFFFFFFFFFFFF80) begin bad++; $display("FAIL lb64_top: got %h want ffffffffffffff80", r_data); end
    run_load(1'b1, 32'h4, 3'b011, 5'd2, 64'hAAAAAAAABBBBBBBB, 64'hCCCCCCCCDDDDDDDD, 0, 0);
`ifdef LOAD_MISALIGN_EN
    total++; if (r_data !== 64'hDDDDDDDDAAAAAAAA || r_nreq != 2 || r_a0 !== 32'h0 || r_a1 !== 32'h8) begin
      bad++; $display("FAIL split64: got %h n=%0d %h %h want ddddddddaaaaaaaa 2 0 8", r_data, r_nreq, r_a0, r_a1); end
`else
    total++; if (r_fault !== 1'b1 || r_data !== 64'h0 || r_nreq != 0) begin
      bad++; $display("FAIL split64_fault: got f=%b d=%h n=%0d want 1 0 0", r_fault, r_data, r_nreq); end
`endif
  endtask

  task automatic test_backpressure();
    run_load(1'b0, 32'h200, 3'b010, 5'd9, 64'h12345678, 64'h0, 0, 3);
    total++; if (r_stable !== 1'b1) begin bad++; $display("FAIL wb_hold_stable: got %b want 1", r_stable); end
    total++; if (r_data !== 64'h12345678 || r_rd !== 5'd9 || r_lat != 3) begin
      bad++; $display("FAIL wb_hold_data: got %h rd=%0d lat=%0d want 12345678 9 3", r_data, r_rd, r_lat); end
    run_load(1'b0, 32'h104, 3'b010, 5'd3, 64'h0BADF00D, 64'h0, 2, 0);
    total++; if (r_lat != 5 || r_a0 !== 32'h104 || r_stable !== 1'b1) begin
      bad++; $display("FAIL mem_stall: got lat=%0d addr=%h stable=%b want 5 00000104 1", r_lat, r_a0, r_stable); end
    total++; if (r_data !== 64'h0BADF00D) begin bad++; $display("FAIL mem_stall_data: got %h want 0badf00d", r_data); end
  endtask

  task automatic test_reset_abort();
    bit spurious;
    if32.req_valid = 1'b1; if32.req_addr = 32'h300; if32.req_f3 = 3'b010; if32.req_rd = 5'd7;
    @(posedge clk); #1;
    if32.req_valid = 1'b0;
    total++; if (if32.mem_req_valid !== 1'b1 || if32.mem_req_addr !== 32'h300) begin
      bad++; $display("FAIL abort_req: got v=%b addr=%h want 1 00000300", if32.mem_req_valid, if32.mem_req_addr); end
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    total++; if (if32.req_ready !== 1'b1 || if32.mem_req_valid !== 1'b0 || if32.wb_valid !== 1'b0) begin
      bad++; $display("FAIL abort_ctrl: got ready=%b mreq=%b wbv=%b want 1 0 0", if32.req_ready, if32.mem_req_valid, if32.wb_valid); end
    total++; if (if32.wb_data !== 32'h0 || if32.wb_rd !== 5'd0 || if32.mem_req_addr !== 32'h0 || if32.wb_fault !== 1'b0) begin
      bad++; $display("FAIL abort_regs: got d=%h rd=%0d addr=%h f=%b want 0", if32.wb_data, if32.wb_rd, if32.mem_req_addr, if32.wb_fault); end
    @(posedge clk); #1;
    rst = 1'b0;
    if32.mem_rsp_valid = 1'b1; if32.mem_rsp_data = 32'hFFFFFFFF;
    spurious = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if32.mem_rsp_valid = 1'b0;
      if (if32.wb_valid !== 1'b0 || if32.mem_req_valid !== 1'b0) spurious = 1'b1;
    end
    total++; if (spurious !== 1'b0) begin bad++; $display("FAIL late_rsp: got activity=%b want 0", spurious); end
    run_load(1'b0, 32'h100, 3'b010, 5'd1, 64'hCAFEF00D, 64'h0, 0, 0);
    total++; if (r_data !== 64'hCAFEF00D || r_lat != 3 || r_rd !== 5'd1) begin
      bad++; $display("FAIL after_reset: got %h lat=%0d rd=%0d want cafef00d 3 1", r_data, r_lat, r_rd); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_aligned32();
    test_extend32();
    test_split32();
    test_illegal();
    test_xlen64();
    test_backpressure();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_aligner.md
# load_aligner

Multi-cycle, parametrised load data unit between the LSU address stage and the register-file writeback port. Accepts one load request, issues one or two naturally aligned bus reads, merges the returned beats, extracts and sign/zero-extends the addressed field, and presents the result with a valid/ready handshake. It supersedes the single-cycle byte-mask reader for the multi-cycle core and adds XLEN=64 support and misaligned-load splitting.

## Interface
- XLEN, 32: datapath and bus width; legal values are 32 and 64.
- ADDR_W, 32: byte-address width.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  load request valid.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_addr  in  ADDR_W  byte address.
- req_f3  in  3  funct3: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU.
- req_rd  in  5  destination tag, returned unchanged on wb_rd.
- mem_req_valid  out  1  bus read request.
- mem_req_ready  in  1  bus accepts the request.
- mem_req_addr  out  ADDR_W  beat address; low log2(XLEN/8) bits are always 0.
- mem_rsp_valid  in  1  read data valid.
- mem_rsp_data  in  XLEN  read data, little-endian.
- wb_valid  out  1  result valid.
- wb_ready  in  1  writeback accepts the result.
- wb_data  out  XLEN  extended load result.
- wb_rd  out  5  captured req_rd.
- wb_fault  out  1  request was illegal; wb_data is 0.

## Operation
- FSM states: IDLE, REQ0, RSP0, REQ1, RSP1, DONE.
- IDLE: req_ready=1. On req_valid, latch addr, f3 and rd, then decode.
  - Illegal request goes to DONE with fault=1 and makes no bus access.
  - Any other request goes to REQ0.
- Illegal f3:
  - 111 for any XLEN.
  - 011 and 110 when XLEN=32.
- Access size: 1, 2, 4 or 8 bytes.
- off = addr mod (XLEN/8). split = (off + size > XLEN/8).
- REQ0: mem_req_valid=1 and mem_req_addr = addr with the low bits cleared. On mem_req_ready, go to RSP0.
- RSP0: wait for mem_rsp_valid, then capture beat0. Go to REQ1 if split, otherwise DONE.
- REQ1: mem_req_addr = beat0 address + XLEN/8, wrapping modulo 2^ADDR_W. On mem_req_ready, go to RSP1.
- RSP1: capture beat1 on mem_rsp_valid, then go to DONE.
- Merge: field = ({beat1, beat0} >> (8*off)), keep the low size bytes.
  - Signed f3 (bit2=0) sign-extends from the field MSB to XLEN.
  - Unsigned f3 zero-extends.
  - LW with XLEN=32 passes all 32 bits unchanged.
- DONE: wb_valid=1. wb_data, wb_rd and wb_fault stay stable until wb_ready, then go to IDLE. The next request is accepted no earlier than the following cycle.
- mem_rsp_valid outside RSP0/RSP1 is ignored. This covers late responses after a reset.
- Outputs are registered, except req_ready and mem_req_valid, which decode directly from state.

## Timing
- Reset, asynchronous: state becomes IDLE; all captured registers clear.
  - Outputs: req_ready=1; mem_req_valid, wb_valid and wb_fault are 0; wb_data, wb_rd and mem_req_addr are 0.
- Latency with a zero-wait bus (mem_req_ready=1, response one cycle after the request), request accepted at cycle T:
  - Aligned load: mem request at T+1, response at T+2, wb_valid at T+3.
  - Split load: second request at T+3, response at T+4, wb_valid at T+5.
  - Fault: wb_valid at T+1.
- Each bus stall cycle (mem_req_ready=0 or no response) adds one cycle. mem_req_addr is held constant while mem_req_valid=1 and mem_req_ready=0.
- Reset asserted in any state aborts the transaction immediately. No wb_valid is produced for the aborted load.

## Configuration
- LOAD_MISALIGN_EN defined: split loads take two beats as described above.
- LOAD_MISALIGN_EN undefined: a split condition is treated like an illegal f3. It goes IDLE to DONE with wb_fault=1 and wb_data=0, makes no bus access, and the REQ1/RSP1 logic is not built.

## Test plan
- XLEN=32, LW at 0x100, beat 0xDEADBEEF:
  - mem_req_addr is 0x100.
  - wb_data is 0xDEADBEEF with wb_fault=0, wb_valid at T+3.
- XLEN=32, LB at 0x103 with beat 0x80AA5511 gives wb_data 0xFFFFFF80. LBU at the same address gives 0x00000080. LHU at 0x102 gives 0x000080AA.
- XLEN=32 with LOAD_MISALIGN_EN, LH at 0x103, beats 0x44332211 at 0x100 and 0x88776655 at 0x104:
  - Two requests, to 0x100 then 0x104.
  - wb_data 0x00005544, wb_valid at T+5.
  - At 0xFFFFFFFF the second request goes to 0x00000000.
  - Without the macro: wb_fault=1, wb_data=0, zero bus requests.
- XLEN=32 with f3=011, and any XLEN with f3=111: wb_fault=1 at T+1, mem_req_valid never asserted.
- XLEN=64:
  - LD at 0x8 with beat 0x8000000000000001 gives 0x8000000000000001.
  - LWU at 0xC gives the upper word zero-extended.
  - LW of 0x80000000 gives 0xFFFFFFFF80000000.
- Backpressure and reset:
  - wb_ready low for 3 cycles: outputs stable and req_ready=0.
  - rst pulsed in RSP0: outputs return to reset values at once. A mem_rsp_valid arriving afterwards produces no wb_valid.
  - The next request completes normally.
